// File: rtl/add_serial_sched.sv
// Scheduler sharing one fixed-latency add_serial datapath among N requesters (IDLE/LAUNCH/WAIT/CAPTURE).
// Define ARB_FIXED_PRIO_EN for lowest-index-wins arbitration; round-robin otherwise.
module add_serial_sched #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2,
    parameter int LAT = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   result,
    output logic [IDW-1:0] result_id,
    output logic           busy,
    output logic           add_en,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    input  logic [W-1:0]   add_out
);

    localparam int TW = $clog2(LAT);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE} state_e;

    state_e         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [IDW-1:0] cur_id_q, cur_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]   add_a_q, add_a_d;
    logic [W-1:0]   add_b_q, add_b_d;
    logic [W-1:0]   result_q, result_d;
    logic [IDW-1:0] result_id_q, result_id_d;

    logic           found;
    logic [IDW-1:0] win_id;
    logic [W-1:0]   win_a, win_b;

    // Winner: first set req bit at offset 0..N-1 above rr_ptr_q, wrapping at N.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        win_a  = '0;
        win_b  = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (j == (int'(rr_ptr_q) + k) % N)) begin
                    found  = 1'b1;
                    win_id = IDW'(j);
                    win_a  = a_in[j*W +: W];
                    win_b  = b_in[j*W +: W];
                end
            end
        end
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no branch can leave one unassigned (no latch).
        state_d     = state_q;
        timer_d     = timer_q;
        cur_id_d    = cur_id_q;
        rr_ptr_d    = rr_ptr_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        result_d    = result_q;
        result_id_d = result_id_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    cur_id_d = win_id;
                    add_a_d  = win_a;
                    add_b_d  = win_b;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                timer_d = TW'(LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (timer_q == '0) begin
                    result_d    = add_out;
                    result_id_d = cur_id_q;
                    state_d     = S_CAPTURE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_CAPTURE: begin
`ifdef ARB_FIXED_PRIO_EN
                rr_ptr_d = '0;
`else
                rr_ptr_d = (int'(cur_id_q) == N - 1) ? '0 : cur_id_q + IDW'(1);
`endif
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples the pre-edge values of the others.
        if (!rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            cur_id_q    <= '0;
            rr_ptr_q    <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            result_q    <= '0;
            result_id_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cur_id_q    <= cur_id_d;
            rr_ptr_q    <= rr_ptr_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            result_q    <= result_d;
            result_id_q <= result_id_d;
        end
    end

    always_comb begin
        ack = '0;
        for (int j = 0; j < N; j++) begin
            if (state_q == S_CAPTURE && int'(cur_id_q) == j) ack[j] = 1'b1;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign add_en    = (state_q == S_LAUNCH);
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign result    = result_q;
    assign result_id = result_id_q;

endmodule

// File: tb/tb_add_serial_sched.sv
// Self-checking bench for add_serial_sched: directed scenarios plus random traffic against a job-level model.
module tb_add_serial_sched;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;
    localparam int LAT = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in, b_in;
    logic [N-1:0]   ack;
    logic [W-1:0]   result;
    logic [IDW-1:0] result_id;
    logic           busy, add_en;
    logic [W-1:0]   add_a, add_b;
    logic [W-1:0]   add_out = '0;

    add_serial_sched #(.N(N), .W(W), .IDW(IDW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .ack(ack), .result(result), .result_id(result_id), .busy(busy),
        .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_out(add_out)
    );

    always #5 clk = ~clk;

    // Adder stand-in: sum becomes visible LAT cycles after the add_en cycle; a wrong value before that.
    logic [W-1:0] adder_v = '0;
    int           adder_cnt = 0;
    always @(posedge clk) begin
        if (add_en === 1'b1) begin
            adder_v   <= add_a + add_b;
            add_out   <= (add_a + add_b) ^ 8'hA5;
            adder_cnt <= LAT - 1;
        end else if (adder_cnt > 0) begin
            adder_cnt <= adder_cnt - 1;
            if (adder_cnt == 1) add_out <= adder_v;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Stimulus state (applied to the DUT at each negedge).
    logic [N-1:0] req_v;
    logic [W-1:0] a_v[N];
    logic [W-1:0] b_v[N];
    bit           rst_v;
    bit           rand_mode   = 1'b0;
    bit           drop_on_ack = 1'b0;

    // Job-level reference model.
    bit           m_out = 1'b0;
    int           m_id = 0, m_grant = 0, m_ptr = 0, m_rid = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_sum = '0, m_res = '0;
    int           ack_ids[$], ack_cycs[$], grant_cycs[$];
    logic [W-1:0] ack_res[$];
    int           n_acks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        bit           idle_now, is_ack;
        logic [N-1:0] exp_ack;
        int           best;
        idle_now = !m_out;
        is_ack   = m_out && (cyc == m_grant + LAT + 2);
        exp_ack  = '0;
        if (is_ack) begin
            exp_ack = N'(1) << m_id;
            m_res   = m_sum;
            m_rid   = m_id;
        end
        check("ack",       32'(ack),       32'(exp_ack));
        check("add_en",    32'(add_en),    32'(m_out && (cyc == m_grant + 1)));
        check("busy",      32'(busy),      32'(m_out && (cyc >= m_grant + 1)));
        check("result",    32'(result),    32'(m_res));
        check("result_id", 32'(result_id), m_rid);
        check("add_a",     32'(add_a),     32'(m_a));
        check("add_b",     32'(add_b),     32'(m_b));

        if (is_ack) begin
            m_out = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            m_ptr = (m_id + 1) % N;
`endif
            ack_ids.push_back(m_id);
            ack_cycs.push_back(cyc);
            ack_res.push_back(m_sum);
            n_acks++;
        end

        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (is_ack && i == m_id) begin
                    if ($urandom_range(1) == 0) req_v[i] = 1'b0;
                    else begin
                        a_v[i] = W'($urandom);
                        b_v[i] = W'($urandom);
                    end
                end else if (m_out && i == m_id) begin
                    if ($urandom_range(9) == 0) req_v[i] = 1'b0;
                    if ($urandom_range(3) == 0) begin
                        a_v[i] = W'($urandom);
                        b_v[i] = W'($urandom);
                    end
                end else if (!req_v[i] && $urandom_range(3) == 0) begin
                    req_v[i] = 1'b1;
                    a_v[i]   = W'($urandom);
                    b_v[i]   = W'($urandom);
                end
            end
            rst_v = ($urandom_range(399) != 0);
        end else if (is_ack && drop_on_ack) begin
            for (int i = 0; i < N; i++) if (i == m_id) req_v[i] = 1'b0;
        end

        rst = rst_v;
        req = req_v;
        for (int i = 0; i < N; i++) begin
            a_in[i*W +: W] = a_v[i];
            b_in[i*W +: W] = b_v[i];
        end

        if (!rst_v) begin
            m_out = 1'b0;
            m_ptr = 0;
            m_res = '0;
            m_rid = 0;
            m_a   = '0;
            m_b   = '0;
        end else if (idle_now && req_v != '0) begin
            // Grant the pending requester with the smallest circular distance from the pointer.
            best = N;
            for (int i = 0; i < N; i++) begin
                if (req_v[i] && ((i - m_ptr + N) % N) < best) begin
                    best  = (i - m_ptr + N) % N;
                    m_id  = i;
                    m_a   = a_v[i];
                    m_b   = b_v[i];
                end
            end
            m_sum   = m_a + m_b;
            m_out   = 1'b1;
            m_grant = cyc;
            grant_cycs.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n;
        n = 0;
        while ((m_out || req_v != '0) && n < max_cyc) begin
            step();
            n++;
        end
        check("drain_done", 32'(m_out || req_v != '0), 32'(0));
    endtask

    initial begin
        int           s, g, c1, c2, snap;
        logic [W-1:0] exp_sum;
        rst_v = 1'b0;
        req_v = '0;
        for (int i = 0; i < N; i++) begin
            a_v[i] = W'($urandom);
            b_v[i] = W'($urandom);
        end
        rst = 1'b0; req = '0; a_in = '0; b_in = '0;
        @(negedge clk);

        // Reset held with all requests up, then round-robin with drop-after-ack.
        req_v = 4'b1111;
        repeat (3) step();
        rst_v = 1'b1;
        drop_on_ack = 1'b1;
        run_until_idle(100);
        check("t3_count", 32'(ack_ids.size()), 32'(4));
        for (int i = 0; i < 4 && i < ack_ids.size(); i++) check("t3_order", ack_ids[i], i);
        for (int i = 0; i < 3 && i + 1 < ack_cycs.size(); i++)
            check("t3_spacing", ack_cycs[i+1] - ack_cycs[i], 13);

        // Single job on requester 2.
        s = ack_ids.size(); g = grant_cycs.size();
        a_v[2] = 8'h3C; b_v[2] = 8'h05; req_v = 4'b0100;
        run_until_idle(40);
        check("t2_id",  ack_ids[s], 2);
        check("t2_res", 32'(ack_res[s]), 32'h41);
        check("t2_lat", ack_cycs[s] - grant_cycs[g], 12);

        // Pointer at 3: wrap and modulo overflow.
        s = ack_ids.size();
        a_v[3] = 8'hFF; b_v[3] = 8'h02; a_v[0] = W'($urandom); req_v = 4'b1001;
        run_until_idle(60);
        check("t4_count", 32'(ack_ids.size() - s), 32'(2));
`ifdef ARB_FIXED_PRIO_EN
        check("t4_first", ack_ids[s], 0);
        check("t4_second", ack_ids[s+1], 3);
        check("t4_res", 32'(ack_res[s+1]), 32'h01);
`else
        check("t4_first", ack_ids[s], 3);
        check("t4_res", 32'(ack_res[s]), 32'h01);
        check("t4_second", ack_ids[s+1], 0);
`endif

        // Abort during WAIT, then a fresh request.
        req_v = 4'b0010;
        for (int n = 0; n < 20 && !(m_out && cyc == m_grant + 4); n++) step();
        check("t5_in_wait", 32'(busy), 32'(1));
        rst_v = 1'b0; req_v = '0;
        step();
        rst_v = 1'b1;
        snap = n_acks;
        repeat (20) step();
        check("t5_no_ack", n_acks - snap, 0);
        a_v[1] = W'($urandom); b_v[1] = W'($urandom);
        exp_sum = a_v[1] + b_v[1];
        req_v = 4'b0010;
        run_until_idle(40);
        check("t5_fresh", n_acks - snap, 1);
        check("t5_res", 32'(ack_res[ack_res.size()-1]), 32'(exp_sum));

        // Two requesters holding req continuously.
        drop_on_ack = 1'b0;
        s = ack_ids.size();
        req_v = 4'b0110;
        for (int n = 0; n < 100 && ack_ids.size() - s < 4; n++) step();
        c1 = 0; c2 = 0;
        for (int i = s; i < ack_ids.size(); i++) begin
            if (ack_ids[i] == 1) c1++;
            if (ack_ids[i] == 2) c2++;
        end
`ifdef ARB_FIXED_PRIO_EN
        check("t6_req1", c1, 4);
        check("t6_req2", c2, 0);
`else
        check("t6_req1", c1, 2);
        check("t6_req2", c2, 2);
`endif
        req_v = '0;
        run_until_idle(40);

        // Random traffic with occasional resets, then drain.
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        drop_on_ack = 1'b1;
        rst_v = 1'b1;
        run_until_idle(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
